mul16_seq: RTL and testbench



---
 rtl/mul16_seq_if.sv | 21 ++
 rtl/mul16_seq.sv | 104 ++++++++++
 tb/tb_mul16_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mul16_seq_if.sv
// Operand/result handshake bundle for mul16_seq.
// The master drives operands and accepts results; the slave is the multiplier.
interface mul16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mul16_seq.sv
// Sequential 16x16 shift-add multiplier giving the low 16 bits of a*b.
// Every accumulation goes through one add16; the loop ends once no multiplier bits remain.
module mul16_seq (
  input  logic        clk,
  input  logic        reset,
  mul16_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT       r_state;
  logic [15:0] r_mcand;
  logic [15:0] r_mplier;
  logic [15:0] r_acc;
  logic        r_inReady;
  logic        r_outValid;

  logic [15:0] w_addend;
  logic [15:0] w_sum;

  assign w_addend = r_mplier[0] ? r_mcand : 16'h0000;

  add16 u_add16 (
    .i_x   (r_acc),
    .i_y   (w_addend),
    .o_sum (w_sum)
  );

  // Handshake flags are registered alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mcand    <= 16'h0000;
      r_mplier   <= 16'h0000;
      r_acc      <= 16'h0000;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mcand   <= bus.a;
            r_mplier  <= bus.b;
            r_acc     <= 16'h0000;
            r_state   <= BUSY;
            r_inReady <= 1'b0;
          end
        end
        BUSY: begin
          r_acc    <= w_sum;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[15:1]};
          // Finish as soon as the shifted-out multiplier has nothing left.
          if (r_mplier[15:1] == 15'h0000) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.product   = r_acc;

endmodule

// Gate-level 16-bit ripple-carry adder, modulo 2^16 with no carry out.
module add16 (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [15:0] o_sum
);

  logic [15:0] w_carry;

  assign w_carry[0] = 1'b0;

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : gBit
    assign o_sum[gi] = i_x[gi] ^ i_y[gi] ^ w_carry[gi];
    if (gi < 15) begin : gCarry
      assign w_carry[gi+1] = (i_x[gi] & i_y[gi]) | (w_carry[gi] & (i_x[gi] ^ i_y[gi]));
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: stimulus queues expected products and BUSY lengths,
// an independent negedge monitor compares them whenever a result is presented.
module tb_mul16_seq;

  typedef struct {
    logic [15:0] prod;
    int          k;
  } expT;

  logic clk;
  logic reset;

  mul16_seq_if bus ();

  mul16_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  expT q[$];
  int  numChecks = 0;
  int  numErrors = 0;
  int  busyCnt = 0;
  bit  prevOutValid = 1'b0;
  bit  expectIdle = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    numChecks++;
    numErrors++;
    $display("[TB] FAIL %s: timed out waiting, got nothing, required event (t=%0t)", name, $time);
  endtask

  task automatic waitInReady();
    for (int n = 0; n < 200 && !bus.in_ready; n++) @(negedge clk);
    if (!bus.in_ready) timeoutFail("wait_in_ready");
  endtask

  task automatic waitOutValid();
    for (int n = 0; n < 200 && !bus.out_valid; n++) @(negedge clk);
    if (!bus.out_valid) timeoutFail("wait_out_valid");
  endtask

  // Issue one operation; stall>0 holds out_ready low that many DONE cycles
  // while wiggling operands and in_valid to show they are ignored.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] expProd, input int k, input int stall);
    expT e;
    waitInReady();
    @(posedge clk); #1;
    bus.out_ready = (stall == 0);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    e.prod = expProd;
    e.k = k;
    q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = (stall > 0);
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    if (stall > 0) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      waitOutValid();
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        bus.in_valid = ~bus.in_valid;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
    end
    waitOutValid();
    waitInReady();
  endtask

  // Monitor: checks BUSY length on the first DONE cycle, product on every DONE
  // cycle, retires the entry on transfer, and expects IDLE right afterwards.
  always @(negedge clk) begin
    checkOutput("no_overlap", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
    if (expectIdle) begin
      checkOutput("idle_after_xfer", {31'd0, bus.in_ready}, 32'd1);
      expectIdle = 1'b0;
    end
    if (bus.in_ready) busyCnt = 0;
    else if (!bus.out_valid) busyCnt++;
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        checkOutput("unexpected_result", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        if (!prevOutValid) checkOutput("busy_cycles", busyCnt, q[0].k);
        checkOutput("product", {16'd0, bus.product}, {16'd0, q[0].prod});
        if (bus.out_ready) begin
          void'(q.pop_front());
          expectIdle = 1'b1;
        end
      end
    end
    prevOutValid = bus.out_valid;
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_product", {16'd0, bus.product}, 32'd0);

    applyStimulus(16'h0003, 16'h0005, 16'h000F, 3, 0);
    applyStimulus(16'h1234, 16'h0000, 16'h0000, 1, 0);
    applyStimulus(16'h1234, 16'h0001, 16'h1234, 1, 0);
    applyStimulus(16'hFFFF, 16'hFFFF, 16'h0001, 16, 0);
    applyStimulus(16'h0001, 16'h8000, 16'h8000, 16, 0);
    applyStimulus(16'hFFFD, 16'h0007, 16'hFFEB, 3, 0);
    applyStimulus(16'h0007, 16'hFFFD, 16'hFFEB, 16, 0);
    applyStimulus(16'h0006, 16'h0007, 16'h002A, 3, 5);
    applyStimulus(16'h0100, 16'h0010, 16'h1000, 5, 0);

    // Abort 0xFF*0xFF with reset during its 4th BUSY cycle.
    waitInReady();
    @(posedge clk); #1;
    bus.a = 16'h00FF;
    bus.b = 16'h00FF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("abort_product", {16'd0, bus.product}, 32'd0);

    applyStimulus(16'h0002, 16'h0002, 16'h0004, 2, 0);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
